// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that shares a single uart_core transmitter between
// NUM_REQ byte requesters. It is the only master on uart_core's register
// bus. Every transfer is a fixed sequence: load the TX register, set tx_en
// in CTRL, wait for intr_tx, then clear tx_en. The rx_en bit and the baud
// divisor in CTRL are kept in step with the configuration inputs.
//
// All bus and status outputs are registered. The next-state process works
// out the values that belong to the state being entered, so the outputs
// line up with the state they describe.

module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT_W = 20,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  logic [15:0]          clks_per_bit_i,
  input  logic                 rx_en_i,
  output logic                 ren_o,
  output logic                 we_o,
  output logic [3:0]           addr_o,
  output logic [31:0]          wdata_o,
  input  logic                 intr_tx_i,
  output logic                 busy_o,
  output logic [ID_W-1:0]      grant_id_o,
  output logic                 timeout_o
);

  localparam logic [3:0] ADDR_CTRL = 4'd0;
  localparam logic [3:0] ADDR_TX   = 4'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_LOAD,
    S_START,
    S_WAIT,
    S_STOP
  } state_t;

  state_t                 state_reg, state_next;
  logic [ID_W-1:0]        ptr_reg, ptr_next;
  logic                   rx_en_q_reg, rx_en_q_next;
  logic [TIMEOUT_W-1:0]   wd_reg, wd_next, wd_inc;

  logic                   we_next;
  logic [3:0]             addr_next;
  logic [31:0]            wdata_next;
  logic [NUM_REQ-1:0]     ready_next;
  logic                   busy_next;
  logic [ID_W-1:0]        grant_next;
  logic                   timeout_next;
  logic [ID_W-1:0]        pick;

  logic [7:0]             req_bytes [NUM_REQ];

  // Split the flat data bus into one byte per requester.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
      assign req_bytes[gi] = req_data_i[8*gi +: 8];
    end
  endgenerate

  // The core is never read.
  assign ren_o = 1'b0;

  assign wd_inc = wd_reg + 1'b1;

  // CTRL register layout: divisor at [18:3], rx_en at [1], tx_en at [0].
  function automatic logic [31:0] ctrl_word(input logic [15:0] cpb,
                                            input logic        rx_en,
                                            input logic        tx_en);
    return {13'b0, cpb, 1'b0, rx_en, tx_en};
  endfunction

  // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] sel;
    logic [ID_W-1:0] cand;
    logic            found;
    int              idx;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!found && valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    return sel;
  endfunction

  // Next-state logic and the registered output values of the state entered.
  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    rx_en_q_next = rx_en_q_reg;
    wd_next      = wd_reg;
    we_next      = 1'b0;
    addr_next    = addr_o;
    wdata_next   = wdata_o;
    ready_next   = '0;
    grant_next   = grant_id_o;
    timeout_next = 1'b0;
    pick         = rr_pick(req_valid_i, ptr_reg);

    case (state_reg)
      S_IDLE: begin
        // A pending rx_en change is written before any new grant.
        if (rx_en_i != rx_en_q_reg) begin
          state_next   = S_CFG;
          we_next      = 1'b1;
          addr_next    = ADDR_CTRL;
          wdata_next   = ctrl_word(clks_per_bit_i, rx_en_i, 1'b0);
          rx_en_q_next = rx_en_i;
        end else if (|req_valid_i) begin
          state_next       = S_LOAD;
          grant_next       = pick;
          we_next          = 1'b1;
          addr_next        = ADDR_TX;
          wdata_next       = {24'b0, req_bytes[pick]};
          ready_next[pick] = 1'b1;
        end
      end

      S_CFG: begin
        state_next = S_IDLE;
      end

      S_LOAD: begin
        state_next   = S_START;
        we_next      = 1'b1;
        addr_next    = ADDR_CTRL;
        wdata_next   = ctrl_word(clks_per_bit_i, rx_en_i, 1'b1);
        rx_en_q_next = rx_en_i;
        wd_next      = '0;
      end

      S_START: begin
        state_next = S_WAIT;
      end

      S_WAIT: begin
        wd_next = wd_inc;
        // Byte completion takes precedence over an expiring watchdog.
        if (intr_tx_i || (wd_inc == '1)) begin
          state_next   = S_STOP;
          timeout_next = !intr_tx_i;
          we_next      = 1'b1;
          addr_next    = ADDR_CTRL;
          wdata_next   = ctrl_word(clks_per_bit_i, rx_en_i, 1'b0);
          rx_en_q_next = rx_en_i;
          if (grant_id_o == ID_W'(NUM_REQ - 1)) ptr_next = '0;
          else                                 ptr_next = grant_id_o + 1'b1;
        end
      end

      S_STOP: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    busy_next = (state_next != S_IDLE);
  end

  // State, arbitration bookkeeping and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= S_IDLE;
      ptr_reg     <= '0;
      rx_en_q_reg <= 1'b0;
      wd_reg      <= '0;
      we_o        <= 1'b0;
      addr_o      <= '0;
      wdata_o     <= '0;
      req_ready_o <= '0;
      busy_o      <= 1'b0;
      grant_id_o  <= '0;
      timeout_o   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      rx_en_q_reg <= rx_en_q_next;
      wd_reg      <= wd_next;
      we_o        <= we_next;
      addr_o      <= addr_next;
      wdata_o     <= wdata_next;
      req_ready_o <= ready_next;
      busy_o      <= busy_next;
      grant_id_o  <= grant_next;
      timeout_o   <= timeout_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter with four requesters and a 4-bit
// watchdog. Inputs change and outputs are sampled 1 ns after the rising
// clock edge.

module tb_uart_tx_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int TIMEOUT_W = 4;
  localparam int ID_W      = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data  = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [15:0]          cpb = 16'd10;
  logic                 rx_en = 1'b0;
  logic                 ren, we;
  logic [3:0]           addr;
  logic [31:0]          wdata;
  logic                 intr_tx = 1'b0;
  logic                 busy;
  logic [ID_W-1:0]      grant_id;
  logic                 timeout;

  int n_checks  = 0;
  int n_pass    = 0;
  int ready_cnt = 0;

  uart_tx_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_data_i    (req_data),
    .req_ready_o   (req_ready),
    .clks_per_bit_i(cpb),
    .rx_en_i       (rx_en),
    .ren_o         (ren),
    .we_o          (we),
    .addr_o        (addr),
    .wdata_o       (wdata),
    .intr_tx_i     (intr_tx),
    .busy_o        (busy),
    .grant_id_o    (grant_id),
    .timeout_o     (timeout)
  );

  always #5 clk = ~clk;

  // Total ready pulses seen, one sample per cycle.
  always @(negedge clk) begin
    if (!rst) ready_cnt <= ready_cnt + $countones(req_ready);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Called at the sample point of the IDLE cycle in which the request is
  // visible; returns at the sample point of the IDLE cycle after STOP.
  task automatic do_xfer(input int id, input logic [7:0] b, input logic [31:0] base,
                         input bit drop);
    logic [31:0] exp_ready;
    exp_ready = 32'd1 << id;
    tick();
    check("load_we",    32'(we),        32'd1);
    check("load_addr",  32'(addr),      32'd4);
    check("load_wdata", wdata,          {24'b0, b});
    check("load_ready", 32'(req_ready), exp_ready);
    check("load_grant", 32'(grant_id),  32'(id));
    check("load_busy",  32'(busy),      32'd1);
    if (drop) req_valid[id] = 1'b0;
    tick();
    check("start_we",    32'(we),        32'd1);
    check("start_addr",  32'(addr),      32'd0);
    check("start_wdata", wdata,          base | 32'd1);
    check("start_ready", 32'(req_ready), 32'd0);
    tick();
    check("wait_we",    32'(we),   32'd0);
    check("wait_wdata", wdata,     base | 32'd1);
    tick();
    intr_tx = 1'b1;
    tick();
    intr_tx = 1'b0;
    check("stop_we",      32'(we),      32'd1);
    check("stop_addr",    32'(addr),    32'd0);
    check("stop_wdata",   wdata,        base);
    check("stop_timeout", 32'(timeout), 32'd0);
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_we",   32'(we),   32'd0);
    $display("xfer id=%0d byte=0x%02h ctrl=0x%0h", id, b, base);
  endtask

  initial begin
    int rc0;
    int bad;

    // ---- reset state ----
    #1 rst = 1'b1;
    #1;
    check("rst_we",      32'(we),        32'd0);
    check("rst_busy",    32'(busy),      32'd0);
    check("rst_ready",   32'(req_ready), 32'd0);
    check("rst_wdata",   wdata,          32'd0);
    check("rst_timeout", 32'(timeout),   32'd0);
    check("rst_ren",     32'(ren),       32'd0);
    tick();
    rst = 1'b0;

    // ---- 1: single byte from requester 0 ----
    req_data[7:0] = 8'hA5;
    req_valid     = 4'b0001;
    do_xfer(0, 8'hA5, 32'h50, 1'b1);

    // ---- 2: all requesters, round-robin order 0,1,2,3,0 ----
    do_reset();
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b1111;
    rc0 = ready_cnt;
    do_xfer(0, 8'h10, 32'h50, 1'b0);
    do_xfer(1, 8'h11, 32'h50, 1'b0);
    do_xfer(2, 8'h12, 32'h50, 1'b0);
    do_xfer(3, 8'h13, 32'h50, 1'b0);
    do_xfer(0, 8'h10, 32'h50, 1'b0);
    req_valid = 4'b0000;
    check("rr_ready_count", 32'(ready_cnt - rc0), 32'd5);

    // ---- 3: rx_en change takes priority over a pending request ----
    do_reset();
    req_data  = {8'hC3, 8'h3C, 8'h77, 8'h0F};
    req_valid = 4'b0100;
    rx_en     = 1'b1;
    tick();
    check("cfg_we",    32'(we),        32'd1);
    check("cfg_addr",  32'(addr),      32'd0);
    check("cfg_wdata", wdata,          32'h52);
    check("cfg_ready", 32'(req_ready), 32'd0);
    check("cfg_busy",  32'(busy),      32'd1);
    $display("cfg write ctrl=0x%0h", wdata);
    tick();
    check("cfg_idle_busy", 32'(busy), 32'd0);
    do_xfer(2, 8'h3C, 32'h52, 1'b1);

    // ---- 4: watchdog expiry, then the next requester is served ----
    req_valid = 4'b1001;
    tick();
    check("to_load_grant", 32'(grant_id),  32'd3);
    check("to_load_ready", 32'(req_ready), 32'h8);
    check("to_load_wdata", wdata,          32'hC3);
    req_valid[3] = 1'b0;
    tick();
    check("to_start_wdata", wdata, 32'h53);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (timeout || we || !busy) bad++;
    end
    check("to_wait_quiet", 32'(bad), 32'd0);
    tick();
    check("to_stop_timeout", 32'(timeout), 32'd1);
    check("to_stop_we",      32'(we),      32'd1);
    check("to_stop_wdata",   wdata,        32'h52);
    $display("timeout id=3 ctrl=0x%0h", wdata);
    tick();
    check("to_idle_timeout", 32'(timeout), 32'd0);
    check("to_idle_busy",    32'(busy),    32'd0);
    do_xfer(0, 8'h0F, 32'h52, 1'b1);

    // ---- 5: intr_tx on the last watchdog cycle; intr_tx in IDLE ----
    req_valid = 4'b0010;
    tick();
    check("edge_load_grant", 32'(grant_id), 32'd1);
    req_valid[1] = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) tick();
    intr_tx = 1'b1;
    tick();
    intr_tx = 1'b0;
    check("edge_stop_timeout", 32'(timeout), 32'd0);
    check("edge_stop_we",      32'(we),      32'd1);
    check("edge_stop_wdata",   wdata,        32'h52);
    $display("edge xfer id=1 done on last watchdog cycle timeout=%0d", timeout);
    tick();
    check("edge_idle_busy", 32'(busy), 32'd0);
    intr_tx = 1'b1;
    tick();
    intr_tx = 1'b0;
    check("idle_intr_busy", 32'(busy), 32'd0);
    check("idle_intr_we",   32'(we),   32'd0);
    tick();
    check("idle_intr_busy2", 32'(busy), 32'd0);

    // ---- 6: asynchronous reset during WAIT, restart from requester 0 ----
    req_valid = 4'b0101;
    tick();
    check("ar_load_grant", 32'(grant_id), 32'd2);
    tick();
    tick();
    tick();
    check("ar_wait_busy", 32'(busy), 32'd1);
    rx_en = 1'b0;
    rst   = 1'b1;
    #1;
    check("ar_we",      32'(we),        32'd0);
    check("ar_busy",    32'(busy),      32'd0);
    check("ar_grant",   32'(grant_id),  32'd0);
    check("ar_wdata",   wdata,          32'd0);
    check("ar_addr",    32'(addr),      32'd0);
    check("ar_ready",   32'(req_ready), 32'd0);
    check("ar_timeout", 32'(timeout),   32'd0);
    $display("async reset in WAIT busy=%0d we=%0d", busy, we);
    #2 rst = 1'b0;
    do_xfer(0, 8'h0F, 32'h50, 1'b1);
    do_xfer(2, 8'h3C, 32'h50, 1'b1);
    req_valid = 4'b0000;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
